reg_port_sequencer: RTL and testbench

//   Initiator side of the 32x32 dual-read register file interface. Accepts operand-fetch

---
 rtl/reg_port_sequencer.sv | 157 +++++++++++++++
 tb/tb_reg_port_sequencer.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_port_sequencer.sv
// Initiator for a 32x32 dual-read register file: arbitrates operand fetches against
// write-backs, runs one READ or WRITE strobe at a time and holds read operands for the consumer.
module reg_port_sequencer #(
    parameter int unsigned WB_MAX_BURST = 4,
    parameter bit          ZERO_R0      = 1'b1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_rs,
    input  logic [4:0]  req_rt,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_d1,
    output logic [31:0] rsp_d2,
    input  logic        wb_valid,
    output logic        wb_ready,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic        RF_READ,
    output logic        RF_WRITE,
    output logic [4:0]  RF_ADDR_R1,
    output logic [4:0]  RF_ADDR_R2,
    output logic [4:0]  RF_ADDR_W,
    output logic [31:0] RF_DATA_W,
    input  logic [31:0] RF_DATA_R1,
    input  logic [31:0] RF_DATA_R2,
    output logic [1:0]  dbg_state
);

    // Handshakes: a transfer happens on a rising CLK edge where valid and ready are both 1.
    // Ready may depend on valid; valid must not depend on ready and, once raised, holds its
    // payload until the transfer. rsp_valid likewise holds rsp_d1/rsp_d2 until rsp_ready.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2,
        ST_RSP  = 2'd3
    } state_e;

    localparam logic [3:0] BURST_MAX = 4'(WB_MAX_BURST);

    state_e      state_q, state_d;
    logic [3:0]  burst_cnt_q, burst_cnt_d;
    logic [4:0]  addr_r1_q, addr_r1_d;
    logic [4:0]  addr_r2_q, addr_r2_d;
    logic [4:0]  addr_w_q, addr_w_d;
    logic [31:0] data_w_q, data_w_d;
    logic [31:0] rsp_d1_q, rsp_d1_d;
    logic [31:0] rsp_d2_q, rsp_d2_d;
    logic        pick_wr;
    logic        pick_rd;

    // Writes win unless a read is waiting and the write burst has run out.
    always_comb begin
        pick_wr = wb_valid && (!req_valid || (burst_cnt_q < BURST_MAX));
        pick_rd = req_valid && !pick_wr;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            burst_cnt_q <= '0;
            addr_r1_q   <= '0;
            addr_r2_q   <= '0;
            addr_w_q    <= '0;
            data_w_q    <= '0;
            rsp_d1_q    <= '0;
            rsp_d2_q    <= '0;
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
            addr_r1_q   <= addr_r1_d;
            addr_r2_q   <= addr_r2_d;
            addr_w_q    <= addr_w_d;
            data_w_q    <= data_w_d;
            rsp_d1_q    <= rsp_d1_d;
            rsp_d2_q    <= rsp_d2_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        addr_r1_d   = addr_r1_q;
        addr_r2_d   = addr_r2_q;
        addr_w_d    = addr_w_q;
        data_w_d    = data_w_q;
        rsp_d1_d    = rsp_d1_q;
        rsp_d2_d    = rsp_d2_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_wr) begin
                    state_d  = ST_WR;
                    addr_w_d = wb_addr;
                    data_w_d = wb_data;
                    // pick_wr with a waiting read implies the count is below the cap.
                    burst_cnt_d = req_valid ? (burst_cnt_q + 4'd1) : '0;
                end else if (pick_rd) begin
                    state_d     = ST_RD;
                    addr_r1_d   = req_rs;
                    addr_r2_d   = req_rt;
                    burst_cnt_d = '0;
                end else begin
                    burst_cnt_d = '0;
                end
            end
            ST_WR: begin
                state_d = ST_IDLE;
            end
            ST_RD: begin
                state_d  = ST_RSP;
                rsp_d1_d = (ZERO_R0 && (addr_r1_q == 5'd0)) ? 32'd0 : RF_DATA_R1;
                rsp_d2_d = (ZERO_R0 && (addr_r2_q == 5'd0)) ? 32'd0 : RF_DATA_R2;
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Every strobe and ready is forced low while RST is high so nothing leaks out mid-reset.
    always_comb begin
        req_ready = 1'b0;
        wb_ready  = 1'b0;
        RF_READ   = 1'b0;
        RF_WRITE  = 1'b0;
        rsp_valid = 1'b0;
        if (!RST) begin
            case (state_q)
                ST_IDLE: begin
                    wb_ready  = pick_wr;
                    req_ready = pick_rd;
                end
                ST_WR:   RF_WRITE  = !(ZERO_R0 && (addr_w_q == 5'd0));
                ST_RD:   RF_READ   = 1'b1;
                ST_RSP:  rsp_valid = 1'b1;
                default: ;
            endcase
        end
    end

    assign RF_ADDR_R1 = addr_r1_q;
    assign RF_ADDR_R2 = addr_r2_q;
    assign RF_ADDR_W  = addr_w_q;
    assign RF_DATA_W  = data_w_q;
    assign rsp_d1     = rsp_d1_q;
    assign rsp_d2     = rsp_d2_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_reg_port_sequencer.sv
// Bench for reg_port_sequencer: directed and random traffic against a shadow register model;
// a negedge monitor scores responses, RF strobes, latencies and handshake rules.
module tb_reg_port_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [4:0]  req_rs, req_rt;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_d1, rsp_d2;
    logic        wb_valid, wb_ready;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        RF_READ, RF_WRITE;
    logic [4:0]  RF_ADDR_R1, RF_ADDR_R2, RF_ADDR_W;
    logic [31:0] RF_DATA_W, RF_DATA_R1, RF_DATA_R2;
    logic [1:0]  dbg_state;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        int          cyc;
    } wexp_t;

    logic [63:0] exp_q[$];
    wexp_t       wexp_q[$];
    int          racc_q[$];
    logic [36:0] wb_pend_q[$];
    logic [9:0]  req_pend_q[$];
    bit          op_log[$];
    logic [31:0] rf_mem[32];
    logic [31:0] shadow[32];
    logic [63:0] last_rsp;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int wr_pulses = 0, rd_pulses = 0, exp_wr_pulses = 0, exp_rd_pulses = 0, wb_fires = 0;
    int gap_pct = 0;
    int rsp_mode = 0;

    always #5 clk = ~clk;

    reg_port_sequencer #(.WB_MAX_BURST(4), .ZERO_R0(1'b1)) dut (
        .CLK(clk), .RST(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_rs(req_rs), .req_rt(req_rt),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_d1(rsp_d1), .rsp_d2(rsp_d2),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
        .RF_READ(RF_READ), .RF_WRITE(RF_WRITE),
        .RF_ADDR_R1(RF_ADDR_R1), .RF_ADDR_R2(RF_ADDR_R2), .RF_ADDR_W(RF_ADDR_W),
        .RF_DATA_W(RF_DATA_W), .RF_DATA_R1(RF_DATA_R1), .RF_DATA_R2(RF_DATA_R2),
        .dbg_state(dbg_state)
    );

    function automatic logic [31:0] init_val(input int i);
        return 32'hC0DE_0000 + (32'(i) * 32'h0013_0101);
    endfunction

    // Reference: r0 always reads 0; any other register returns its last accepted write.
    function automatic logic [31:0] rd_model(input logic [4:0] a);
        return (a == 5'd0) ? 32'd0 : shadow[a];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
        end
    endtask

    // Register file model: commits on the edge that closes a WRITE cycle.
    initial begin : rf_env
        for (int i = 0; i < 32; i++) rf_mem[i] = init_val(i);
        forever begin
            @(posedge clk);
            if (RF_WRITE) rf_mem[RF_ADDR_W] = RF_DATA_W;
        end
    end
    assign RF_DATA_R1 = rf_mem[RF_ADDR_R1];
    assign RF_DATA_R2 = rf_mem[RF_ADDR_R2];

    initial begin : wb_drv
        logic        fired;
        logic [36:0] item;
        wb_valid = 1'b0;
        wb_addr  = '0;
        wb_data  = '0;
        forever begin
            @(negedge clk);
            fired = wb_valid && wb_ready;
            @(posedge clk);
            #1;
            if (fired) wb_valid = 1'b0;
            if (!wb_valid && wb_pend_q.size() > 0 && $urandom_range(0, 99) >= gap_pct) begin
                item     = wb_pend_q.pop_front();
                wb_valid = 1'b1;
                wb_addr  = item[36:32];
                wb_data  = item[31:0];
            end
        end
    end

    initial begin : req_drv
        logic       fired;
        logic [9:0] item;
        req_valid = 1'b0;
        req_rs    = '0;
        req_rt    = '0;
        forever begin
            @(negedge clk);
            fired = req_valid && req_ready;
            @(posedge clk);
            #1;
            if (fired) req_valid = 1'b0;
            if (!req_valid && req_pend_q.size() > 0 && $urandom_range(0, 99) >= gap_pct) begin
                item      = req_pend_q.pop_front();
                req_valid = 1'b1;
                req_rs    = item[9:5];
                req_rt    = item[4:0];
            end
        end
    end

    initial begin : rsp_drv
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rsp_mode)
                0:       rsp_ready = 1'b1;
                1:       rsp_ready = 1'($urandom_range(0, 1));
                default: rsp_ready = 1'b0;
            endcase
        end
    end

    initial begin : monitor
        logic        prev_rsp_valid, prev_rsp_ready, prev_wr, prev_rd;
        logic [63:0] prev_rsp, e;
        wexp_t       w;
        int          acc;
        for (int i = 0; i < 32; i++) shadow[i] = init_val(i);
        prev_rsp_valid = 1'b0; prev_rsp_ready = 1'b0; prev_wr = 1'b0; prev_rd = 1'b0;
        prev_rsp = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                // Whatever was in flight is abandoned by reset.
                exp_q.delete(); wexp_q.delete(); racc_q.delete();
                exp_wr_pulses = wr_pulses;
                exp_rd_pulses = rd_pulses;
                prev_rsp_valid = 1'b0; prev_rsp_ready = 1'b0; prev_wr = 1'b0; prev_rd = 1'b0;
                continue;
            end
            if (RF_READ || RF_WRITE) check("rf_rw_exclusive", 64'(RF_READ & RF_WRITE), 64'd0);
            if (req_ready || wb_ready) begin
                check("ready_exclusive", 64'(req_ready & wb_ready), 64'd0);
                check("ready_needs_valid", 64'((req_ready & ~req_valid) | (wb_ready & ~wb_valid)), 64'd0);
            end
            if (rsp_valid) check("no_ready_in_rsp", 64'(req_ready | wb_ready), 64'd0);
            if (wb_valid && wb_ready) begin
                wb_fires++;
                op_log.push_back(1'b0);
                if (wb_addr != 5'd0) begin
                    shadow[wb_addr] = wb_data;
                    wexp_q.push_back('{addr: wb_addr, data: wb_data, cyc: cyc});
                    exp_wr_pulses++;
                end
            end
            if (req_valid && req_ready) begin
                op_log.push_back(1'b1);
                exp_q.push_back({rd_model(req_rs), rd_model(req_rt)});
                racc_q.push_back(cyc);
                exp_rd_pulses++;
            end
            if (RF_WRITE) begin
                wr_pulses++;
                check("rf_write_width", 64'(prev_wr), 64'd0);
                if (wexp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL rf_write_unexpected: got write addr %0d data 0x%0h, expected no write", RF_ADDR_W, RF_DATA_W);
                end else begin
                    w = wexp_q.pop_front();
                    check("rf_write_addr", 64'(RF_ADDR_W), 64'(w.addr));
                    check("rf_write_data", 64'(RF_DATA_W), 64'(w.data));
                    check("rf_write_latency", 64'(cyc - w.cyc), 64'd1);
                end
            end
            if (RF_READ) begin
                rd_pulses++;
                check("rf_read_width", 64'(prev_rd), 64'd0);
            end
            if (rsp_valid && !prev_rsp_valid) begin
                if (racc_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL rsp_unexpected: got rsp_valid=1, expected 0 (no read outstanding)");
                end else begin
                    acc = racc_q.pop_front();
                    check("rsp_latency", 64'(cyc - acc), 64'd2);
                end
            end
            if (rsp_valid && prev_rsp_valid && !prev_rsp_ready)
                check("rsp_hold", {rsp_d1, rsp_d2}, prev_rsp);
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL rsp_extra: got 0x%0h, expected no response", {rsp_d1, rsp_d2});
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_data", {rsp_d1, rsp_d2}, e);
                end
                last_rsp = {rsp_d1, rsp_d2};
            end
            prev_rsp_valid = rsp_valid;
            prev_rsp_ready = rsp_ready;
            prev_rsp       = {rsp_d1, rsp_d2};
            prev_wr        = RF_WRITE;
            prev_rd        = RF_READ;
        end
    end

    task automatic drain(input int budget);
        int k = 0;
        while (k < budget && !(wb_pend_q.size() == 0 && req_pend_q.size() == 0 && !wb_valid &&
                               !req_valid && exp_q.size() == 0 && wexp_q.size() == 0)) begin
            @(negedge clk);
            k++;
        end
        check("drain_timeout", 64'(k < budget), 64'd1);
        repeat (2) @(negedge clk);
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: got no finish, expected bench to end before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int          k, base, wr0, wf0;
        logic [6:0]  seq;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_state", 64'(dbg_state), 64'd0);
        check("reset_handshake_outs", 64'({req_ready, wb_ready, rsp_valid}), 64'd0);
        check("reset_rf_strobes", 64'({RF_READ, RF_WRITE}), 64'd0);
        check("reset_rf_addr", 64'({RF_ADDR_R1, RF_ADDR_R2, RF_ADDR_W}), 64'd0);
        check("reset_rf_data_w", 64'(RF_DATA_W), 64'd0);
        check("reset_rsp_data", {rsp_d1, rsp_d2}, 64'd0);

        // Write then read back with rt=0.
        wb_pend_q.push_back({5'd5, 32'hDEAD_BEEF});
        drain(2000);
        req_pend_q.push_back({5'd5, 5'd0});
        drain(2000);
        check("t1_d1", 64'(last_rsp[63:32]), 64'h0000_0000_DEAD_BEEF);
        check("t1_d2", 64'(last_rsp[31:0]), 64'd0);

        // Six writes contend with one read: expect W W W W R W W.
        base = op_log.size();
        for (int i = 0; i < 6; i++) wb_pend_q.push_back({5'(i + 1), $urandom()});
        req_pend_q.push_back({5'd1, 5'd6});
        drain(2000);
        check("t2_op_count", 64'(op_log.size() - base), 64'd7);
        seq = '0;
        for (int i = 0; i < 7; i++)
            if (base + i < op_log.size()) seq = {seq[5:0], op_log[base + i]};
        check("t2_order", 64'(seq), 64'b0000100);

        // Write to r0 is consumed without a strobe; r0 reads as zero.
        wr0 = wr_pulses;
        wf0 = wb_fires;
        wb_pend_q.push_back({5'd0, 32'h0000_1234});
        drain(2000);
        check("t3_wb_handshake", 64'(wb_fires - wf0), 64'd1);
        check("t3_no_rf_write", 64'(wr_pulses - wr0), 64'd0);
        req_pend_q.push_back({5'd0, 5'd5});
        drain(2000);
        check("t3_r0_reads_zero", 64'(last_rsp[63:32]), 64'd0);

        // Consumer stalls: response held, next request blocked until rsp_ready.
        rsp_mode = 2;
        req_pend_q.push_back({5'd5, 5'd1});
        req_pend_q.push_back({5'd2, 5'd3});
        k = 0;
        while (!rsp_valid && k < 200) begin @(negedge clk); k++; end
        check("t4_rsp_seen", 64'(rsp_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            check("t4_rsp_held", 64'(rsp_valid), 64'd1);
            check("t4_req_blocked", 64'(req_ready), 64'd0);
            @(negedge clk);
        end
        rsp_mode = 0;
        @(negedge clk);
        check("t4_rsp_taken_cycle", 64'({rsp_valid, rsp_ready, req_ready}), 64'b110);
        @(negedge clk);
        check("t4_accept_after_rsp", 64'(req_valid & req_ready), 64'd1);
        drain(2000);

        // Reset in the middle of a read.
        req_pend_q.push_back({5'd5, 5'd9});
        k = 0;
        @(posedge clk); #2;
        while (!RF_READ && k < 100) begin @(posedge clk); #2; k++; end
        check("t5_rd_reached", 64'(RF_READ), 64'd1);
        rst = 1'b1;
        #1;
        check("t5_rf_read_gated", 64'({RF_READ, RF_WRITE}), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("t5_rsp_dropped", 64'(rsp_valid), 64'd0);
        check("t5_state_idle", 64'(dbg_state), 64'd0);
        drain(2000);

        // Random mix with idle gaps and a flaky consumer.
        gap_pct  = 30;
        rsp_mode = 1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 1) == 1)
                wb_pend_q.push_back({5'($urandom_range(0, (i % 4 == 0) ? 31 : 7)), $urandom()});
            else
                req_pend_q.push_back({5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))});
        end
        drain(30000);
        rsp_mode = 0;
        gap_pct  = 0;
        for (int i = 0; i < 40; i++) begin
            wb_pend_q.push_back({5'($urandom_range(0, 7)), $urandom()});
            req_pend_q.push_back({5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))});
        end
        drain(5000);

        check("rf_write_pulse_count", 64'(wr_pulses), 64'(exp_wr_pulses));
        check("rf_read_pulse_count", 64'(rd_pulses), 64'(exp_rd_pulses));
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
